out_drain_ctrl: RTL
===================

# out_drain_ctrl

Parametrised result-drain controller between the MAC array and the result memory. When a computation finishes it walks the active tile of `pe_result` row-major, packs `LANES` results per memory word with a selectable post-processing mode, and streams words to memory under a valid/ready handshake at up to one word per cycle. It supersedes the fixed 128x128, two-per-word, no-backpressure drain path and adds tile sizing, a base address and output modes.

## Interface
- `DATA_IN_WIDTH`, 24: width of one PE result, two's complement.
- `LANE_WIDTH`, 32: width of one packed lane; must be >= `DATA_IN_WIDTH`.
- `LANES`, 2: results per memory word; `DATA_OUT_WIDTH` = `LANE_WIDTH*LANES`.
- `MAC_SIZE`, 128: array dimension.
- `ADDR_OUT_WIDTH`, 23: memory word-address width.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pe_result` in `DATA_IN_WIDTH` x [0:MAC_SIZE-1][0:MAC_SIZE-1]: array results, stable from `done_finish` until `done`.
- `done_finish` in 1: array finished; start request.
- `base_addr` in `ADDR_OUT_WIDTH`: first word address.
- `active_rows`, `active_cols` in `$clog2(MAC_SIZE)+1`: tile size; values > `MAC_SIZE` clamp to `MAC_SIZE`.
- `mode` in 2: 00 zero-pad, 01 sign-extend, 10 ReLU (negative -> 0, then zero-pad), 11 same as 00.
- `mem_ready` in 1: memory accepts the presented word this cycle.
- `mem_write_enb` out 1: word valid.
- `res_out_addr` out `ADDR_OUT_WIDTH`: word address.
- `res_data` out `DATA_OUT_WIDTH`: packed word.
- `busyb` out 1: low while draining.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, WRT, DONE.
- IDLE: `busyb`=1. On `done_finish`=1, latch `base_addr`, clamped `active_rows`/`active_cols` and `mode`; row=col=0. If either size is 0 go to DONE with no writes, else go to WRT and register the first word.
- WRT: word = results [row][col .. col+LANES-1]; col (lowest column) occupies the most-significant lane, col+LANES-1 the least. Lanes with column >= `active_cols` are all-zero. Each row starts a new word; words per row = ceil(cols/LANES); total writes = rows x ceil(cols/LANES).
- Lane formatting per `mode`: zero-pad = `LANE_WIDTH-DATA_IN_WIDTH` zero MSBs; sign-extend = replicate bit `DATA_IN_WIDTH-1`; ReLU = value < 0 -> all zero, else zero-pad.
- Transfer = `mem_write_enb` & `mem_ready` at a rising edge. On transfer, address +1 (wraps modulo 2^`ADDR_OUT_WIDTH`) and the next word is registered. While `mem_ready`=0, `res_data`/`res_out_addr` are held unchanged and `mem_write_enb` stays 1.
- On the transfer of the last word: go to DONE, `mem_write_enb`=0.
- DONE: `done`=1, `busyb`=1 for one cycle, then IDLE.
- `done_finish` outside IDLE is ignored; size/base/mode changes mid-drain have no effect.

## Timing
- Reset (`rst_n`=0 at an edge), from any state: state=IDLE, `mem_write_enb`=0, `done`=0, `busyb`=1, `res_out_addr`=0, `res_data`=0, counters 0. Reset mid-drain aborts with no `done` pulse.
- `done_finish` sampled in IDLE at edge N -> first word valid, `busyb`=0 after edge N+1 (1-cycle latency).
- `mem_ready` held 1: one word per cycle, no bubbles, including across row boundaries.
- Last transfer at edge M -> `mem_write_enb`=0 and `done`=1 after M; `done`=0 after M+1; a new `done_finish` is accepted from M+2.
- Zero-size tile: `done` high in the cycle after the start edge, no `mem_write_enb`.
- `busyb` is 0 exactly while in WRT.

## Test plan
- Defaults, full 128x128, `mem_ready`=1, `base_addr`=0, mode 00: 8192 writes on consecutive cycles, addresses 0..8191, first word = {8'b0,pe[0][0],8'b0,pe[0][1]}, last = {8'b0,pe[127][126],8'b0,pe[127][127]}, then one `done` pulse.
- Backpressure: 4x4 tile, `mem_ready` toggled 1,0,0,1,... -> exactly 8 writes, data/address stable during stalls, no duplicated or skipped word.
- Partial tile 3x5, `LANES`=2, `base_addr`=100: 9 writes at 100..108; words 102, 105, 108 carry pe[r][4] in the upper lane and a zero lower lane.
- Modes: pe[0][0]=24'hFFFFFE, pe[0][1]=24'h000005 -> mode 00 lane 32'h00FFFFFE/32'h00000005; 01 32'hFFFFFFFE; 10 32'h00000000/32'h00000005.
- `rst_n`=0 for one cycle mid-drain: next cycle `mem_write_enb`=0, IDLE, no `done`; a fresh start re-drains from `base_addr`.
- Zero tile (`active_rows`=0) and `done_finish` pulsed during WRT: no writes, single `done` pulse; the mid-drain start is ignored.

Source files
------------

// File: rtl/out_drain_ctrl.sv
// Result-drain controller: walks the active tile of pe_result row-major, packs
// LANES formatted results per word and streams them out under valid/ready.
module out_drain_ctrl #(
  parameter int unsigned DATA_IN_WIDTH  = 24,
  parameter int unsigned LANE_WIDTH     = 32,
  parameter int unsigned LANES          = 2,
  parameter int unsigned MAC_SIZE       = 128,
  parameter int unsigned ADDR_OUT_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_IN_WIDTH-1:0]       pe_result [0:MAC_SIZE-1][0:MAC_SIZE-1],
  input  logic                           done_finish,
  input  logic [ADDR_OUT_WIDTH-1:0]      base_addr,
  input  logic [$clog2(MAC_SIZE):0]      active_rows,
  input  logic [$clog2(MAC_SIZE):0]      active_cols,
  input  logic [1:0]                     mode,
  input  logic                           mem_ready,
  output logic                           mem_write_enb,
  output logic [ADDR_OUT_WIDTH-1:0]      res_out_addr,
  output logic [LANE_WIDTH*LANES-1:0]    res_data,
  output logic                           busyb,
  output logic                           done
);

  localparam int unsigned DATA_OUT_WIDTH = LANE_WIDTH * LANES;
  localparam int unsigned IW = $clog2(MAC_SIZE);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRT, S_DONE} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_rows, r_cols, r_row, r_col;
  logic [1:0]                  r_mode;
  logic [ADDR_OUT_WIDTH-1:0]   r_addr;
  logic [DATA_OUT_WIDTH-1:0]   r_data;
  logic                        r_wen, r_busyb, r_done;

  logic [CW-1:0]               w_rows_cl, w_cols_cl, w_nrow, w_ncol, w_ncols;
  logic [1:0]                  w_nmode;
  logic [31:0]                 w_col_nx, w_c;
  logic                        w_row_end, w_last;
  logic [DATA_IN_WIDTH-1:0]    w_val;
  logic [DATA_OUT_WIDTH-1:0]   w_word;

  function automatic logic [LANE_WIDTH-1:0] fmt_lane(input logic [DATA_IN_WIDTH-1:0] v,
                                                     input logic [1:0] md);
    case (md)
      2'b01:   fmt_lane = LANE_WIDTH'($signed(v));
      2'b10:   fmt_lane = v[DATA_IN_WIDTH-1] ? '0 : LANE_WIDTH'(v);
      default: fmt_lane = LANE_WIDTH'(v);
    endcase
  endfunction

  // The next word position comes from the live inputs when starting and from the
  // latched tile otherwise, so one packer serves both the first and later words.
  always_comb begin
    w_rows_cl = (active_rows > CW'(MAC_SIZE)) ? CW'(MAC_SIZE) : active_rows;
    w_cols_cl = (active_cols > CW'(MAC_SIZE)) ? CW'(MAC_SIZE) : active_cols;
    w_col_nx  = 32'(r_col) + 32'(LANES);
    w_row_end = (w_col_nx >= 32'(r_cols));
    w_last    = w_row_end && ((r_row + CW'(1)) == r_rows);
    w_nrow    = r_row;
    w_ncol    = w_col_nx[CW-1:0];
    w_ncols   = r_cols;
    w_nmode   = r_mode;
    if (r_state == S_IDLE) begin
      w_nrow  = '0;
      w_ncol  = '0;
      w_ncols = w_cols_cl;
      w_nmode = mode;
    end else if (w_row_end) begin
      w_nrow  = r_row + CW'(1);
      w_ncol  = '0;
    end
    w_word = '0;
    w_c    = '0;
    w_val  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_c   = 32'(w_ncol) + l;
      w_val = pe_result[w_nrow[IW-1:0]][w_c[IW-1:0]];
      if (w_c < 32'(w_ncols))
        w_word[(LANES-1-l)*LANE_WIDTH +: LANE_WIDTH] = fmt_lane(w_val, w_nmode);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rows  <= '0;
      r_cols  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_mode  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wen   <= 1'b0;
      r_busyb <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (done_finish) begin
            r_rows <= w_rows_cl;
            r_cols <= w_cols_cl;
            r_mode <= mode;
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= base_addr;
            if (w_rows_cl == '0 || w_cols_cl == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WRT;
              r_wen   <= 1'b1;
              r_busyb <= 1'b0;
              r_data  <= w_word;
            end
          end
        end
        S_WRT: begin
          if (r_wen && mem_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_wen   <= 1'b0;
              r_busyb <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_row  <= w_nrow;
              r_col  <= w_ncol;
              r_addr <= r_addr + ADDR_OUT_WIDTH'(1);
              r_data <= w_word;
            end
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_write_enb = r_wen;
  assign res_out_addr  = r_addr;
  assign res_data      = r_data;
  assign busyb         = r_busyb;
  assign done          = r_done;

endmodule
